// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// The FSM state encoding and the pair-count helper live here.
package serial_magnitude_comparator_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  localparam result_t RESULT_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

  // Number of 2-bit digit pairs in an operand of the given width.
  function automatic int pair_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/two_bit_comparator.sv
// Combinational 2-bit unsigned compare slice; exactly one output is high.
module two_bit_comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Sequential unsigned magnitude comparator: walks latched operands MSB-first,
// one 2-bit pair per clock, and stops at the first unequal pair.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NPAIRS = pair_count(WIDTH);
  localparam int IDX_W  = $clog2(NPAIRS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAIRS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  result_t          result_q, result_d;
  logic             load;

  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       a_pair, b_pair;
  logic             slice_eq, slice_gt, slice_lt;

  // NOTE: operand registers carry no reset; their content is only observed
  // after a load, so a reset would add routing without changing behaviour.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Pair mux: pair 0 is the MSB pair of the latched operands.
  always_comb begin
    a_pair = 2'b00;
    b_pair = 2'b00;
    for (int i = 0; i < NPAIRS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_pair = a_q[WIDTH-1-2*i -: 2];
        b_pair = b_q[WIDTH-1-2*i -: 2];
      end
    end
  end

  two_bit_comparator u_slice (
    .a  (a_pair),
    .b  (b_pair),
    .eq (slice_eq),
    .gt (slice_gt),
    .lt (slice_lt)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    result_d = result_q;
    load     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          idx_d    = '0;
          result_d = RESULT_NONE;
          load     = 1'b1;
        end
      end
      S_RUN: begin
        if (slice_gt) begin
          result_d.gt = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (slice_lt) begin
          result_d.lt = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          result_d.eq = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= RESULT_NONE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign eq   = result_q.eq;
  assign gt   = result_q.gt;
  assign lt   = result_q.lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8): directed cases
// plus randomized traffic against an arithmetic reference model.
module tb_serial_magnitude_comparator;

  localparam int W  = 8;
  localparam int NP = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, eq, gt, lt;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] res;      // {eq, gt, lt}
    int         done_cyc; // edge index at which done must appear
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   busy_until = -1;  // edge of the last expected done

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: first differing 2-bit pair counted from the MSB.
  function automatic int first_diff_pair(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int p = 0; p < NP; p++)
      if (((x >> (W - 2 - 2 * p)) & 2'b11) != ((y >> (W - 2 - 2 * p)) & 2'b11)) return p;
    return NP - 1;
  endfunction

  // Drive one start pulse; the model decides whether the DUT may accept it.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    int e0;
    exp_t x;
    e0 = cyc + 1;
    a = av;
    b = bv;
    start = 1'b1;
    if (e0 > busy_until) begin
      x.res      = {av == bv, av > bv, av < bv};
      x.done_cyc = e0 + first_diff_pair(av, bv) + 1;
      busy_until = x.done_cyc;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int edge_n);
    while (cyc < edge_n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    busy_until = -1;
    #1;
    check("reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
    step(1);
    rst_n = 1'b1;
  endtask

  // Monitor: compare at the falling edge whenever done is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        check("missing_done", 0, 1);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("result_eq_gt_lt", {eq, gt, lt}, x.res);
          check("done_latency", cyc, x.done_cyc);
          check("busy_low_at_done", busy, 0);
        end
      end
    end
  end

  initial begin
    int e;
    logic [W-1:0] ra, rb, mask;

    // Reset state.
    #2;
    check("por_outputs", {busy, done, eq, gt, lt}, 5'b0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // 1: equal operands, full latency.
    issue(8'h5A, 8'h5A);
    check("busy_after_start", busy, 1);
    wait_until(busy_until + 2);

    // 2: MSB pair differs.
    issue(8'hC0, 8'h40);
    wait_until(busy_until + 2);

    // 3: difference only in LSB pair.
    issue(8'h12, 8'h13);
    wait_until(busy_until + 2);

    // 4: start while busy is ignored.
    issue(8'h30, 8'h20);
    issue(8'h00, 8'hFF);
    wait_until(busy_until + 3);

    // 5: reset mid-comparison, then a fresh start.
    issue(8'h01, 8'h02);
    step(1);
    apply_reset();
    step(6);
    check("no_done_after_reset", {done, eq, gt, lt}, 4'b0);
    issue(8'h03, 8'h03);
    wait_until(busy_until + 2);

    // 6: start held high in the done cycle.
    issue(8'h44, 8'h44);
    e = busy_until;
    wait_until(e);
    issue(8'hFF, 8'h00);
    check("result_cleared_on_restart", {eq, gt, lt}, 3'b000);
    check("busy_on_restart", busy, 1);
    wait_until(busy_until + 2);
    check("result_holds", {eq, gt, lt}, 3'b010);

    // Randomized traffic with shared prefixes and random gaps.
    for (int n = 0; n < 60; n++) begin
      ra   = W'($urandom);
      mask = W'((1 << (2 * $urandom_range(0, NP))) - 1);
      rb   = (ra & ~mask) | (W'($urandom) & mask);
      issue(ra, rb);
      step($urandom_range(0, 5));
    end

    // Drain with a bounded wait.
    wait_until(busy_until + 3);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
